// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding, width limits,
// counter sizing helper and an elaboration-time WIDTH range check.
// Imported by serial_adder; the macro is expanded once at module scope.

`ifndef SERIAL_ADDER_PKG_SV
`define SERIAL_ADDER_PKG_SV

// Elaboration-time guard: stops the build if WIDTH falls outside 1..32.
`define SERIAL_ADDER_WIDTH_CHECK(W) \
   if (((W) < serial_adder_pkg::WIDTH_MIN) || ((W) > serial_adder_pkg::WIDTH_MAX)) begin : g_width_check \
      $error("serial_adder: WIDTH must lie in 1..32"); \
   end

package serial_adder_pkg;

   localparam int WIDTH_MIN = 1;
   localparam int WIDTH_MAX = 32;

   // IDLE waits for start, RUN feeds one bit pair per edge, DONE is the result pulse.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Bit counter width: clog2(WIDTH), but never narrower than one bit.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

`endif

// File: rtl/fulladder.sv
// Single-bit full adder cell: s = a^b^c, cin = majority(a,b,c) (carry out).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.

module fulladder (
   output logic s,
   output logic cin,
   input  logic a,
   input  logic b,
   input  logic c
);

   assign s   = a ^ b ^ c;
   assign cin = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: {cout,sum} = a_in + b_in + c_in using one fulladder, LSB first.
// Latency: start accepted at E0, done high in the cycle after edge E_WIDTH.
// Backpressure: start is only honoured in IDLE; requests during RUN/DONE are dropped.

module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             c_in,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy,
   output logic             done
);

   `SERIAL_ADDER_WIDTH_CHECK(WIDTH)

   localparam int            CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;     // result bits being assembled, hidden from sum
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             fa_s;
   logic             fa_co;

   fulladder u_fa (
      .s   (fa_s),
      .cin (fa_co),
      .a   (a_q[0]),
      .b   (b_q[0]),
      .c   (carry_q)
   );

   // Next-state and datapath updates; outputs busy/done decoded from state.
   always_comb begin
      logic [WIDTH-1:0] acc_sh;
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      cnt_d   = cnt_q;
      busy    = 1'b0;
      done    = 1'b0;
      // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
      acc_sh           = acc_q >> 1;
      acc_sh[WIDTH-1]  = fa_s;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a_in;
               b_d     = b_in;
               carry_d = c_in;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            busy    = 1'b1;
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            acc_d   = acc_sh;
            carry_d = fa_co;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               // Publish the complete result in one step so sum never shows partial bits.
               sum_d   = acc_sh;
               cout_d  = fa_co;
               state_d = DONE;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any addition in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         cnt_q   <= cnt_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8, 1 and 3.
// Inputs driven and outputs sampled on the falling clock edge.
// Expected values are hand-computed constants or a plain a+b+c sum.

module tb_serial_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic       start8, c8, cout8, busy8, done8;
   logic [7:0] a8, b8, sum8;
   logic       start1, c1, cout1, busy1, done1;
   logic [0:0] a1, b1, sum1;
   logic       start3, c3, cout3, busy3, done3;
   logic [2:0] a3, b3, sum3;

   int n_cmp = 0;
   int n_err = 0;

   serial_adder #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8), .c_in(c8),
      .sum(sum8), .cout(cout8), .busy(busy8), .done(done8)
   );
   serial_adder #(.WIDTH(1)) u_w1 (
      .clk(clk), .rst(rst), .start(start1), .a_in(a1), .b_in(b1), .c_in(c1),
      .sum(sum1), .cout(cout1), .busy(busy1), .done(done1)
   );
   serial_adder #(.WIDTH(3)) u_w3 (
      .clk(clk), .rst(rst), .start(start3), .a_in(a3), .b_in(b3), .c_in(c3),
      .sum(sum3), .cout(cout3), .busy(busy3), .done(done3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
         $error("%s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One WIDTH=8 addition; optionally pulses a competing start at RUN index poke.
   task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input int poke,
                       output logic [8:0] res, output logic [8:0] res_at0,
                       output int busy_n, output int done_n, output int done_idx);
      busy_n   = 0;
      done_n   = 0;
      done_idx = -1;
      @(negedge clk);
      start8 = 1'b1; a8 = a; b8 = b; c8 = c;
      @(negedge clk);                       // E0 has accepted the request
      start8 = 1'b0; a8 = ~a; b8 = 8'h55; c8 = ~c;
      res_at0 = {cout8, sum8};
      for (int idx = 0; idx < 12; idx++) begin
         if (busy8) busy_n++;
         if (done8) begin
            done_n++;
            if (done_idx < 0) done_idx = idx;
         end
         if (idx == poke) begin
            start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
         end else begin
            start8 = 1'b0;
         end
         @(negedge clk);
      end
      start8 = 1'b0;
      res = {cout8, sum8};
   endtask

   initial begin
      logic [8:0] res, res0, exp9;
      int         bn, dn, di, k, dcount;

      rst = 1'b1;
      start8 = 0; a8 = 0; b8 = 0; c8 = 0;
      start1 = 0; a1 = 0; b1 = 0; c1 = 0;
      start3 = 0; a3 = 0; b3 = 0; c3 = 0;
      #12;
      check("rst_sum8",  {24'd0, sum8}, 32'd0);
      check("rst_cout8", {31'd0, cout8}, 32'd0);
      check("rst_busy8", {31'd0, busy8}, 32'd0);
      check("rst_done8", {31'd0, done8}, 32'd0);
      check("rst_sum3",  {28'd0, cout3, sum3}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // 0 + 0 + 0
      add8(8'h00, 8'h00, 1'b0, -1, res, res0, bn, dn, di);
      check("zero_res",   {23'd0, res}, 32'h000);
      check("zero_busy",  bn, 8);
      check("zero_donen", dn, 1);
      check("zero_doneat", di, 8);

      // FF + 01: carry ripples through every bit
      add8(8'hFF, 8'h01, 1'b0, -1, res, res0, bn, dn, di);
      check("ff01_res",   {23'd0, res}, 32'h100);
      check("ff01_doneat", di, 8);
      check("ff01_donen", dn, 1);

      // 5A + A5 + 1, then 3C + 0F with the previous result held until done
      add8(8'h5A, 8'hA5, 1'b1, -1, res, res0, bn, dn, di);
      check("5aa5_res", {23'd0, res}, 32'h100);
      add8(8'h3C, 8'h0F, 1'b0, -1, res, res0, bn, dn, di);
      check("3c0f_held", {23'd0, res0}, 32'h100);
      check("3c0f_res",  {23'd0, res}, 32'h04B);

      // Competing start three cycles into RUN must be dropped
      add8(8'h21, 8'h13, 1'b0, 2, res, res0, bn, dn, di);
      check("poke_held",  {23'd0, res0}, 32'h04B);
      check("poke_res",   {23'd0, res}, 32'h034);
      check("poke_donen", dn, 1);
      check("poke_busy",  bn, 8);

      // Reset in the fourth RUN cycle aborts the addition
      @(negedge clk);
      start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; c8 = 1'b0;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_sum",  {24'd0, sum8}, 32'd0);
      check("abort_cout", {31'd0, cout8}, 32'd0);
      check("abort_busy", {31'd0, busy8}, 32'd0);
      check("abort_done", {31'd0, done8}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      dcount = 0;
      repeat (12) begin
         @(negedge clk);
         if (done8) dcount++;
      end
      check("abort_nodone", dcount, 0);
      add8(8'h12, 8'h34, 1'b0, -1, res, res0, bn, dn, di);
      check("after_abort_res", {23'd0, res}, 32'h046);

      // Random WIDTH=8 operands against a plain a+b+c
      for (int i = 0; i < 200; i++) begin
         logic [7:0] ra, rb;
         logic       rc;
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = 1'($urandom);
         exp9 = 9'(ra) + 9'(rb) + 9'(rc);
         add8(ra, rb, rc, -1, res, res0, bn, dn, di);
         check("rand8", {23'd0, res}, {23'd0, exp9});
      end

      // Exhaustive WIDTH=1
      for (int v = 0; v < 8; v++) begin
         logic [2:0] vv;
         vv = 3'(v);
         @(negedge clk);
         start1 = 1'b1; a1 = vv[2]; b1 = vv[1]; c1 = vv[0];
         @(negedge clk);
         start1 = 1'b0;
         for (k = 0; k < 10 && !done1; k++) @(negedge clk);
         check("w1_latency", k, 1);
         check("w1_res", {30'd0, cout1, sum1}, 32'(vv[2]) + 32'(vv[1]) + 32'(vv[0]));
      end

      // Exhaustive WIDTH=3
      for (int v = 0; v < 128; v++) begin
         logic [6:0] vv;
         vv = 7'(v);
         @(negedge clk);
         start3 = 1'b1; a3 = vv[6:4]; b3 = vv[3:1]; c3 = vv[0];
         @(negedge clk);
         start3 = 1'b0;
         for (k = 0; k < 10 && !done3; k++) @(negedge clk);
         check("w3_latency", k, 3);
         check("w3_res", {28'd0, cout3, sum3}, 32'(vv[6:4]) + 32'(vv[3:1]) + 32'(vv[0]));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
